// File: rtl/enc_pkg.sv
// Shared types and helpers for the one-hot/bit-vector encoder family.
// Provides the encoder state enum, default width and a constant-safe clog2.
package enc_pkg;

  typedef enum logic {
    ENC_IDLE = 1'b0,
    ENC_EMIT = 1'b1
  } enc_state_t;

  localparam int unsigned ENC_WIDTH_DEFAULT = 8;

  // Ceiling log2 usable in parameter/localparam expressions
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/prio_index.sv
// Combinational priority index: position of the lowest (or highest) set bit,
// plus flags for "exactly one bit set" and "any bit set".
module prio_index
  import enc_pkg::*;
#(
  parameter int unsigned WIDTH     = ENC_WIDTH_DEFAULT,
  parameter bit          MSB_FIRST = 1'b0,
  localparam int unsigned CODE_W   = clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]  vec,
  output logic [CODE_W-1:0] index,
  output logic              single_bit,
  output logic              any_bit
);

  // Later loop iterations win, so scan towards the preferred end
  always_comb begin
    index = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (vec[i]) index = CODE_W'(i);
      end
    end else begin
      for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
        if (vec[i]) index = CODE_W'(i);
      end
    end
  end

  // Clearing the lowest set bit leaves zero only for a single-bit vector
  always_comb begin
    any_bit    = |vec;
    single_bit = any_bit && ((vec & (vec - WIDTH'(1))) == '0);
  end

endmodule

// File: rtl/onehot_encoder_8to3_seq.sv
// Sequential bit-vector encoder: emits the index of every set bit, one beat each.
// Define ENC_MSB_FIRST_EN to emit highest index first instead of lowest.
module onehot_encoder_8to3_seq
  import enc_pkg::*;
#(
  parameter int unsigned  WIDTH  = ENC_WIDTH_DEFAULT,
  localparam int unsigned CODE_W = clog2(WIDTH),
  localparam int unsigned CNT_W  = CODE_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code,
  output logic              out_last,
  output logic              out_none,
  output logic [CNT_W-1:0]  out_cnt
);

`ifdef ENC_MSB_FIRST_EN
  localparam bit MSB_FIRST = 1'b1;
`else
  localparam bit MSB_FIRST = 1'b0;
`endif

  enc_state_t        state, state_d;
  logic [WIDTH-1:0]  pending, pending_d;
  logic [CNT_W-1:0]  cnt_d;
  logic [CNT_W-1:0]  popcnt;
  logic [CODE_W-1:0] idx_d;
  logic              single_d;
  logic              any_d;
  logic              accept;
  logic              beat_done;
  logic              emit_d;

  always_comb begin
    popcnt = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      popcnt = popcnt + CNT_W'(in_data[i]);
    end
  end

  // Next-state: capture in IDLE, retire one bit per accepted beat in EMIT
  always_comb begin
    state_d   = state;
    pending_d = pending;
    cnt_d     = out_cnt;
    accept    = in_valid && in_ready;
    beat_done = out_valid && out_ready;
    case (state)
      ENC_IDLE: begin
        if (accept) begin
          pending_d = in_data;
          cnt_d     = popcnt;
          state_d   = ENC_EMIT;
        end
      end
      ENC_EMIT: begin
        if (beat_done) begin
          pending_d[out_code] = 1'b0;
          if (out_last) begin
            state_d = ENC_IDLE;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d   = ENC_IDLE;
        pending_d = '0;
        cnt_d     = '0;
      end
    endcase
    emit_d = (state_d == ENC_EMIT);
  end

  // Beat fields are pre-decoded from the next pending value so they leave a flop
  prio_index #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_prio (
    .vec        (pending_d),
    .index      (idx_d),
    .single_bit (single_d),
    .any_bit    (any_d)
  );

  // An empty pending while emitting can only mean an all-zero vector
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ENC_IDLE;
      pending   <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_code  <= '0;
      out_last  <= 1'b0;
      out_none  <= 1'b0;
      out_cnt   <= '0;
    end else begin
      state     <= state_d;
      pending   <= pending_d;
      in_ready  <= (state_d == ENC_IDLE);
      out_valid <= emit_d;
      out_code  <= emit_d ? idx_d : '0;
      out_last  <= emit_d && (single_d || !any_d);
      out_none  <= emit_d && !any_d;
      out_cnt   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_onehot_encoder_8to3_seq.sv
// Self-checking bench for onehot_encoder_8to3_seq against a set-bit-list model.
// Honours ENC_MSB_FIRST_EN for the expected emission order.
module tb_onehot_encoder_8to3_seq;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_code;
  logic       out_last;
  logic       out_none;
  logic [3:0] out_cnt;

  int n_cmp;
  int n_err;
  int exp_q[$];

  onehot_encoder_8to3_seq #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_code  (out_code),
    .out_last  (out_last),
    .out_none  (out_none),
    .out_cnt   (out_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected code sequence: list of set-bit positions in emission order
  function automatic void build_exp(input logic [7:0] v);
    exp_q.delete();
    for (int i = 0; i < 8; i++) if (v[i]) exp_q.push_back(i);
`ifdef ENC_MSB_FIRST_EN
    exp_q.reverse();
`endif
    if (exp_q.size() == 0) exp_q.push_back(0);
  endfunction

  // Send one vector and check every beat; rlen==0 means random out_ready
  task automatic run_vec(input logic [7:0] v, input logic [7:0] rpat, input int rlen,
                         input string tag);
    int k, cyc, nb;
    logic [7:0] acc;
    logic r;
    build_exp(v);
    nb  = exp_q.size();
    acc = '0;
    cyc = 0;
    while (in_ready !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s in_ready_wait: got %b want 1", tag, in_ready);
    end
    in_valid = 1'b1;
    in_data  = v;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    k   = 0;
    cyc = 0;
    while (k < nb && cyc < 100) begin
      r = (rlen == 0) ? 1'($urandom % 2) : rpat[cyc % rlen];
      out_ready = r;
      in_valid  = (r && k == nb - 1) ? 1'b0 : 1'($urandom % 2);
      in_data   = 8'($urandom);
      n_cmp++;
      if (out_valid !== 1'b1 || out_code !== 3'(exp_q[k]) || out_last !== (k == nb - 1) ||
          out_none !== (v == 8'h00) || out_cnt !== 4'($countones(v)) || in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL %s beat%0d vec=%h: valid=%b code=%0d last=%b none=%b cnt=%0d rdy=%b want valid=1 code=%0d last=%b none=%b cnt=%0d rdy=0",
                 tag, k, v, out_valid, out_code, out_last, out_none, out_cnt, in_ready,
                 exp_q[k], (k == nb - 1), (v == 8'h00), $countones(v));
      end
      if (r) begin
        if (v != 8'h00) acc = acc | (8'(1) << out_code);
        k++;
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    n_cmp++;
    if (k != nb) begin
      n_err++;
      $display("FAIL %s beat_timeout vec=%h: got %0d beats want %0d", tag, v, k, nb);
    end
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s bubble vec=%h: valid=%b rdy=%b want valid=0 rdy=1", tag, v, out_valid, in_ready);
    end
    n_cmp++;
    if (acc !== v) begin
      n_err++;
      $display("FAIL %s roundtrip: got %h want %h", tag, acc, v);
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hFF;
    out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_code !== 3'd0 || out_last !== 1'b0 ||
          out_none !== 1'b0 || out_cnt !== 4'd0) begin
        n_err++;
        $display("FAIL reset_hold: valid=%b rdy=%b code=%0d last=%b none=%b cnt=%0d want all 0",
                 out_valid, in_ready, out_code, out_last, out_none, out_cnt);
      end
    end
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: rdy=%b valid=%b want rdy=1 valid=0", in_ready, out_valid);
    end
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0 || out_code !== 3'd0 || in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL idle_ready: valid=%b code=%0d rdy=%b want valid=0 code=0 rdy=1",
                 out_valid, out_code, in_ready);
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_single();
    run_vec(8'b0010_0000, 8'h01, 1, "single");
  endtask

  task automatic test_backpressure();
    run_vec(8'b1001_0010, 8'h19, 5, "backpressure");
  endtask

  task automatic test_zero_ones();
    run_vec(8'h00, 8'h01, 1, "zero");
    run_vec(8'hFF, 8'h01, 1, "all_ones");
  endtask

  task automatic test_mid_reset();
    int cyc;
    build_exp(8'hF0);
    cyc = 0;
    while (in_ready !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b1;
    in_data  = 8'hF0;
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n_cmp++;
    if (out_valid !== 1'b1 || out_code !== 3'(exp_q[0])) begin
      n_err++;
      $display("FAIL midreset_first: valid=%b code=%0d want valid=1 code=%0d",
               out_valid, out_code, exp_q[0]);
    end
    @(negedge clk);
    out_ready = 1'b0;
    rst_n     = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_code !== 3'd0 || out_cnt !== 4'd0) begin
      n_err++;
      $display("FAIL midreset_clear: valid=%b rdy=%b code=%0d cnt=%0d want 0 0 0 0",
               out_valid, in_ready, out_code, out_cnt);
    end
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL midreset_no_beats: valid=%b code=%0d rdy=%b want valid=0 rdy=1",
                 out_valid, out_code, in_ready);
      end
    end
    out_ready = 1'b0;
    run_vec(8'h01, 8'h01, 1, "after_reset");
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      run_vec(8'($urandom), 8'h00, 0, "random");
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] vecs[5];
    vecs[0] = 8'h81;
    vecs[1] = 8'h3C;
    vecs[2] = 8'h01;
    vecs[3] = 8'h80;
    vecs[4] = 8'h55;
    for (int n = 0; n < 5; n++) begin
      run_vec(vecs[n], 8'h01, 1, "back_to_back");
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    @(posedge clk);
    test_reset();
    test_single();
    test_backpressure();
    test_zero_ones();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/onehot_encoder_8to3_seq.md
Name: onehot_encoder_8to3_seq

Overview:
- Inverse of the team's 3-to-8 one-hot decoder.
- Accepts a WIDTH-bit bit-vector over a valid/ready handshake.
- Emits the binary index of every set bit, one per output beat, lowest index first. The last beat of each vector is flagged.
- Sits between event/request collectors and code-driven consumers such as adders, muxes and the 3-to-8 decoder itself.

Parameters:
- WIDTH, 8, input vector width; power of two, minimum 2.
- CODE_W, $clog2(WIDTH), output code width; derived, not to be overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  in_data valid
- in_ready  output  1  block can accept a vector
- in_data  input  WIDTH  bit-vector to encode
- out_valid  output  1  out_code/out_last/out_none valid
- out_ready  input  1  consumer accepts current beat
- out_code  output  CODE_W  index of current set bit
- out_last  output  1  current beat is the final beat of the vector
- out_none  output  1  vector was all-zero (single beat, out_code=0)
- out_cnt  output  CODE_W+1  number of set bits in the vector; valid on every beat, constant per vector

Behaviour:
- Interface decision: one clock, clk; reset rst_n is synchronous and active-low, sampled on the rising edge of clk.
- Reset values: in_ready=0 during reset, 1 on the first cycle after release. out_valid=0, out_code=0, out_last=0, out_none=0, out_cnt=0. The internal pending register is cleared.
- State machine:
  - IDLE: in_ready=1, out_valid=0. On in_valid&&in_ready, capture in_data into pending, compute out_cnt, go to EMIT.
  - EMIT: in_ready=0, out_valid=1. out_code = lowest set index of pending.
  - EMIT on out_valid&&out_ready:
    - Clear that bit in pending.
    - If out_last=1, go to IDLE; otherwise stay in EMIT.
- Latency: vector accepted in cycle N gives first out_valid in cycle N+1. Each subsequent beat costs 1 cycle when out_ready is held high.
- Throughput: one idle bubble cycle between vectors; in_ready returns in the cycle after the last beat handshakes. An N-bit-set vector occupies N+1 cycles minimum.
- Derived outputs: out_code, out_last and out_none are decoded from registered pending/state only, so they are glitch-free and stable.
- Stall: while out_valid=1 && out_ready=0, all outputs hold unchanged.
- out_last=1 when pending has exactly one bit set, or when the vector was zero.
- Zero vector: accepted normally. Produces exactly one beat with out_none=1, out_last=1, out_code=0, out_cnt=0.
- All-ones vector: WIDTH beats, codes 0..WIDTH-1 in order; out_cnt=WIDTH, so CODE_W+1 bits are required.
- in_valid while in EMIT: ignored; the input is not sampled. The upstream holds per the handshake.
- Reset mid-EMIT: pending is discarded, no further beats are emitted, and the block returns to the reset values above.
- out_ready asserted with out_valid=0: no effect.

Optional Feature:
- Macro ENC_MSB_FIRST_EN.
- Defined: emission order is highest set index first. out_last is unchanged in meaning (final remaining bit).
- Undefined (default): lowest index first.
- out_cnt, out_none, handshake and timing are identical in both builds.

Decomposition:
- Shared package enc_pkg:
  - State typedef enc_state_t {ENC_IDLE, ENC_EMIT}.
  - Localparam ENC_WIDTH_DEFAULT=8.
  - Function clog2 helper, for tools lacking $clog2 in localparams.
- One natural combinational sub-module, prio_index (WIDTH, MSB_FIRST parameter): bit-vector in; index out plus single_bit and any_bit flags.
- The popcount for out_cnt stays inline.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 cycles with in_valid=1, in_data=8'hFF. Required: out_valid=0, in_ready=0, all outputs 0. After release, in_ready=1 in the next cycle.
- Single one-hot: send 8'b00100000 with out_ready=1. Required: one beat, out_code=5, out_last=1, out_cnt=1, out_none=0; in_ready=1 one cycle later.
- Multi-bit with backpressure: send 8'b10010010 and toggle out_ready 1,0,0,1,1. Required: codes 1,4,7 in order, each held stable during stalls; out_last only on code 7; out_cnt=3 on all beats.
- Zero and all-ones: send 8'h00, then 8'hFF. Required:
  - 8'h00: one beat with out_none=1, out_code=0, out_last=1.
  - 8'hFF: 8 beats, codes 0..7; out_cnt=8; out_last on 7.
- Mid-operation reset: send 8'hF0, consume one beat (code 4), then pulse rst_n=0 for 1 cycle. Required: no codes 5-7 appear; the next vector 8'h01 yields code 0 correctly.
- Macro build with ENC_MSB_FIRST_EN: send 8'b10010010. Required: codes 7,4,1 with out_last on 1. Round-trip each code through the 3-to-8 decoder; the OR of the decoder outputs equals the input vector.
